wgt_read_responder: RTL and testbench
=====================================

WGT_READ_RESPONDER -- requirements
Module: wgt_read_responder

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16, number of output lanes (power of two).
REQ-002 SHALL have parameter WGT_RAM_SIZE, default 8845488, weight RAM depth in words.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per weight word.
REQ-004 SHALL have ports (name direction width meaning):
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- read_en  input  1  request valid, one request per cycle while high.
- wgt_addr  input  $clog2(WGT_RAM_SIZE)  first word address of the request.
- read_wgt_size  input  5  words requested; values above SYSTOLIC_SIZE are clamped to SYSTOLIC_SIZE.
- mem_rd_en  output  1  RAM line read strobe.
- mem_addr_a  output  $clog2(WGT_RAM_SIZE/SYSTOLIC_SIZE)+1  line index holding wgt_addr.
- mem_addr_b  output  same width as mem_addr_a  following line index.
- mem_rdata_a  input  DATA_WIDTH*SYSTOLIC_SIZE  line A data, one cycle after mem_rd_en.
- mem_rdata_b  input  DATA_WIDTH*SYSTOLIC_SIZE  line B data, one cycle after mem_rd_en.
- wgt_valid  output  1  wgt_data valid.
- wgt_data  output  DATA_WIDTH*SYSTOLIC_SIZE  aligned weights; lane 0 in bits [DATA_WIDTH-1:0].
- wgt_last  output  1  final response of a contiguous read_en run.
- wgt_err  output  1  out-of-range request flag (only with WGT_RESP_BOUND_CHECK_EN).

Function
REQ-005 SHALL use a three-stage pipeline: S0 samples the request at edge N; S1 drives mem_rd_en, mem_addr_a and mem_addr_b registered after edge N+1; S2 captures RAM data and registers wgt_data and wgt_valid after edge N+3. Fixed latency is 3 cycles, with throughput of one request per cycle and no backpressure.
REQ-006 SHALL compute line = wgt_addr / SYSTOLIC_SIZE and offset = wgt_addr % SYSTOLIC_SIZE, drive mem_addr_a = line and mem_addr_b = line+1, and carry offset and the clamped size down the pipeline.
REQ-007 SHALL set output lane i to word (wgt_addr+i) for i < size, taken from line A when offset+i < SYSTOLIC_SIZE and from line B otherwise; lanes with i >= size SHALL be zero.
REQ-008 SHALL, for read_wgt_size = 0, still return one response with wgt_valid = 1 and all lanes zero.
REQ-009 SHALL treat line B as all-zero when line+1 exceeds the last RAM line, and SHALL then drive mem_addr_b = 0.
REQ-010 SHALL assert wgt_last together with the response whose request was sampled while read_en=1 with read_en=0 on the next edge; S1 observes that next-edge value.
REQ-011 SHALL hold wgt_data at its last value and keep wgt_valid, wgt_last and mem_rd_en at 0 when there is no request; mem addresses hold.
REQ-012 SHALL let a new run start on the cycle after a run ends, with no idle gap required.

Reset
REQ-013 SHALL, while rst_n=0, asynchronously clear all pipeline valids and drive all outputs to 0 (wgt_data, mem addresses and wgt_err included).
REQ-014 SHALL discard in-flight requests when reset is asserted mid-run; no response for them appears after release.

Configuration
REQ-015 SHALL, with WGT_RESP_BOUND_CHECK_EN defined, set wgt_err=1 alongside a response when wgt_addr + size > WGT_RAM_SIZE. wgt_err SHALL be sticky until reset, and the offending lanes beyond WGT_RAM_SIZE SHALL be zero.
REQ-016 SHALL, without WGT_RESP_BOUND_CHECK_EN, tie wgt_err to 0 and add no check logic.

Structure
REQ-017 SHALL place the default values of SYSTOLIC_SIZE, DATA_WIDTH and WGT_RAM_SIZE and the line-index width function in the shared accelerator package.
REQ-018 SHALL implement the lane shift/mask as sub-module wgt_lane_aligner: combinational, with inputs two lines, offset and size, and output the aligned vector. It SHALL be instantiated before the S2 register.

Verification
REQ-019 Aligned request: addr=32, size=16 -> 3 cycles later wgt_valid=1 and lanes 0..15 = words 32..47; mem_addr_a=2, mem_addr_b=3.
REQ-020 Straddle: addr=37, size=16 -> lanes 0..10 = line2 lanes 5..15 and lanes 11..15 = line3 lanes 0..4.
REQ-021 Remainder: addr=64, size=3 -> lanes 0..2 = words 64..66 and lanes 3..15 = 0; size=0 -> all-zero valid response.
REQ-022 Run of 9 back-to-back requests -> 9 consecutive valids with wgt_last only on the 9th; a second run starting the following cycle gets its own single last.
REQ-023 Reset asserted 2 cycles into a 5-request run -> all outputs 0 immediately and no valid after release until new requests arrive.
REQ-024 With WGT_RESP_BOUND_CHECK_EN: addr=WGT_RAM_SIZE-4, size=16 -> lanes 0..3 = data, lanes 4..15 = 0, wgt_err=1 and remains 1; without the macro wgt_err=0.

Source files
------------

// File: rtl/wgt_read_responder_pkg.sv
// Shared accelerator defaults for the weight read path.
// Holds array geometry defaults and the RAM line-index width helper.
package wgt_read_responder_pkg;

  localparam int unsigned SYSTOLIC_SIZE_DEF = 16;
  localparam int unsigned WGT_RAM_SIZE_DEF  = 8845488;
  localparam int unsigned DATA_WIDTH_DEF    = 8;

  typedef struct packed {
    logic vld;
    logic last;
    logic bzero;
  } rd_flags_t;

  function automatic int unsigned line_aw(
    input int unsigned ram,
    input int unsigned sys
  );
    return $clog2(ram / sys) + 1;
  endfunction

endpackage

// File: rtl/wgt_read_responder_aligner.sv
// Combinational lane aligner: picks words offset.. from two RAM lines
// and zeroes every lane at or above the requested size.
module wgt_lane_aligner #(
  parameter int unsigned SYS = 16,
  parameter int unsigned DW  = 8,
  localparam int unsigned OW = $clog2(SYS),
  localparam int unsigned SW = $clog2(SYS) + 1,
  localparam int unsigned LW = SYS * DW
) (
  input  logic [LW-1:0] line_a_i,
  input  logic [LW-1:0] line_b_i,
  input  logic [OW-1:0] offset_i,
  input  logic [SW-1:0] size_i,
  output logic [LW-1:0] aligned_o
);

  logic [LW-1:0] shifted;

  always_comb begin
    shifted   = LW'({line_b_i, line_a_i} >> (offset_i * DW));
    aligned_o = '0;
    for (int i = 0; i < int'(SYS); i++) begin
      if (i < int'(size_i)) begin
        aligned_o[i*DW +: DW] = shifted[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/wgt_read_responder.sv
// Weight read responder: 3-cycle pipeline turning word requests into
// lane-aligned weight vectors. Optional WGT_RESP_BOUND_CHECK_EN adds wgt_err.
module wgt_read_responder
  import wgt_read_responder_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
  parameter int unsigned WGT_RAM_SIZE  = WGT_RAM_SIZE_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic read_en,
  input  logic [$clog2(WGT_RAM_SIZE)-1:0] wgt_addr,
  input  logic [4:0] read_wgt_size,
  output logic mem_rd_en,
  output logic [line_aw(WGT_RAM_SIZE, SYSTOLIC_SIZE)-1:0] mem_addr_a,
  output logic [line_aw(WGT_RAM_SIZE, SYSTOLIC_SIZE)-1:0] mem_addr_b,
  input  logic [DATA_WIDTH*SYSTOLIC_SIZE-1:0] mem_rdata_a,
  input  logic [DATA_WIDTH*SYSTOLIC_SIZE-1:0] mem_rdata_b,
  output logic wgt_valid,
  output logic [DATA_WIDTH*SYSTOLIC_SIZE-1:0] wgt_data,
  output logic wgt_last,
  output logic wgt_err
);

  localparam int unsigned AW  = $clog2(WGT_RAM_SIZE);
  localparam int unsigned LAW = line_aw(WGT_RAM_SIZE, SYSTOLIC_SIZE);
  localparam int unsigned OW  = $clog2(SYSTOLIC_SIZE);
  localparam int unsigned SW  = OW + 1;
  localparam int unsigned LW  = DATA_WIDTH * SYSTOLIC_SIZE;
  localparam int unsigned LAST_LINE = (WGT_RAM_SIZE - 1) / SYSTOLIC_SIZE;

  logic [LAW-1:0] line_d;
  logic [SW-1:0]  size_d;
  logic           bzero_d;

  logic           s0_vld_q;
  logic [LAW-1:0] s0_line_q;
  logic [OW-1:0]  s0_off_q;
  logic [SW-1:0]  s0_size_q;

  logic           mem_rd_en_q;
  logic [LAW-1:0] mem_addr_a_q;
  logic [LAW-1:0] mem_addr_b_q;
  logic [OW-1:0]  s1_off_q;
  logic [SW-1:0]  s1_size_q;
  logic           s1_bzero_q;
  logic           s1_last_q;

  rd_flags_t      rd_q;
  logic [OW-1:0]  rd_off_q;
  logic [SW-1:0]  rd_size_q;

  logic [LW-1:0]  line_b_sel;
  logic [LW-1:0]  aligned;

  logic           wgt_valid_q;
  logic           wgt_last_q;
  logic [LW-1:0]  wgt_data_q;

`ifdef WGT_RESP_BOUND_CHECK_EN
  logic [AW:0]    sum_d;
  logic           err_d;
`endif

  always_comb begin
    line_d = LAW'(wgt_addr >> OW);
    if (32'(read_wgt_size) > SYSTOLIC_SIZE) begin
      size_d = SW'(SYSTOLIC_SIZE);
    end else begin
      size_d = SW'(read_wgt_size);
    end
`ifdef WGT_RESP_BOUND_CHECK_EN
    sum_d = (AW+1)'(wgt_addr) + (AW+1)'(size_d);
    err_d = sum_d > (AW+1)'(WGT_RAM_SIZE);
    // Trim the request so words past the end of the RAM come out as zero.
    if (err_d) begin
      if ((AW+1)'(wgt_addr) >= (AW+1)'(WGT_RAM_SIZE)) begin
        size_d = '0;
      end else begin
        size_d = SW'((AW+1)'(WGT_RAM_SIZE) - (AW+1)'(wgt_addr));
      end
    end
`endif
  end

  assign bzero_d = s0_line_q >= LAW'(LAST_LINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q  <= 1'b0;
      s0_line_q <= '0;
      s0_off_q  <= '0;
      s0_size_q <= '0;
    end else begin
      s0_vld_q <= read_en;
      if (read_en) begin
        s0_line_q <= line_d;
        s0_off_q  <= wgt_addr[OW-1:0];
        s0_size_q <= size_d;
      end
    end
  end

  // A run ends when the edge after a request sees read_en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en_q  <= 1'b0;
      mem_addr_a_q <= '0;
      mem_addr_b_q <= '0;
      s1_off_q     <= '0;
      s1_size_q    <= '0;
      s1_bzero_q   <= 1'b0;
      s1_last_q    <= 1'b0;
    end else begin
      mem_rd_en_q <= s0_vld_q;
      s1_last_q   <= s0_vld_q & ~read_en;
      if (s0_vld_q) begin
        mem_addr_a_q <= s0_line_q;
        mem_addr_b_q <= bzero_d ? '0 : s0_line_q + LAW'(1);
        s1_off_q     <= s0_off_q;
        s1_size_q    <= s0_size_q;
        s1_bzero_q   <= bzero_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      rd_off_q  <= '0;
      rd_size_q <= '0;
    end else begin
      rd_q.vld   <= mem_rd_en_q;
      rd_q.last  <= mem_rd_en_q & s1_last_q;
      rd_q.bzero <= s1_bzero_q;
      if (mem_rd_en_q) begin
        rd_off_q  <= s1_off_q;
        rd_size_q <= s1_size_q;
      end
    end
  end

  assign line_b_sel = rd_q.bzero ? '0 : mem_rdata_b;

  wgt_lane_aligner #(
    .SYS (SYSTOLIC_SIZE),
    .DW  (DATA_WIDTH)
  ) u_align (
    .line_a_i  (mem_rdata_a),
    .line_b_i  (line_b_sel),
    .offset_i  (rd_off_q),
    .size_i    (rd_size_q),
    .aligned_o (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_valid_q <= 1'b0;
      wgt_last_q  <= 1'b0;
      wgt_data_q  <= '0;
    end else begin
      wgt_valid_q <= rd_q.vld;
      wgt_last_q  <= rd_q.vld & rd_q.last;
      if (rd_q.vld) begin
        wgt_data_q <= aligned;
      end
    end
  end

`ifdef WGT_RESP_BOUND_CHECK_EN
  logic s0_err_q;
  logic s1_err_q;
  logic rd_err_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_err_q <= 1'b0;
      s1_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s0_err_q <= read_en & err_d;
      s1_err_q <= s0_vld_q & s0_err_q;
      rd_err_q <= mem_rd_en_q & s1_err_q;
      if (rd_q.vld && rd_err_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wgt_err = err_q;
`else
  assign wgt_err = 1'b0;
`endif

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr_a = mem_addr_a_q;
  assign mem_addr_b = mem_addr_b_q;
  assign wgt_valid  = wgt_valid_q;
  assign wgt_last   = wgt_last_q;
  assign wgt_data   = wgt_data_q;

endmodule

// File: tb/tb_wgt_read_responder.sv
// Randomized bench for wgt_read_responder against a word-level model
// of the request history and a behavioural line RAM.
module tb_wgt_read_responder;
  import wgt_read_responder_pkg::*;

  localparam int SYS   = 16;
  localparam int DW    = 8;
  localparam int RAM   = 8845488;
  localparam int AW    = $clog2(RAM);
  localparam int LAW   = line_aw(RAM, SYS);
  localparam int LW    = SYS * DW;
  localparam int LINES = RAM / SYS;
  localparam int HN    = 4096;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           read_en = 1'b0;
  logic [AW-1:0]  wgt_addr = '0;
  logic [4:0]     read_wgt_size = '0;
  logic           mem_rd_en;
  logic [LAW-1:0] mem_addr_a;
  logic [LAW-1:0] mem_addr_b;
  logic [LW-1:0]  rdata_a;
  logic [LW-1:0]  rdata_b;
  logic           wgt_valid;
  logic [LW-1:0]  wgt_data;
  logic           wgt_last;
  logic           wgt_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 8;
  logic h_en [HN];
  int   h_addr [HN];
  int   h_size [HN];
  logic [LW-1:0] exp_data = '0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  wgt_read_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_en       (read_en),
    .wgt_addr      (wgt_addr),
    .read_wgt_size (read_wgt_size),
    .mem_rd_en     (mem_rd_en),
    .mem_addr_a    (mem_addr_a),
    .mem_addr_b    (mem_addr_b),
    .mem_rdata_a   (rdata_a),
    .mem_rdata_b   (rdata_b),
    .wgt_valid     (wgt_valid),
    .wgt_data      (wgt_data),
    .wgt_last      (wgt_last),
    .wgt_err       (wgt_err)
  );

  function automatic logic [7:0] word(input int a);
    if (a < 0 || a >= RAM) return 8'h00;
    return 8'(a * 7) ^ 8'(a >> 9) ^ 8'h5A;
  endfunction

  function automatic logic [LW-1:0] line_data(input int ln);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < SYS; i++) v[i*DW +: DW] = word(ln * SYS + i);
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) begin
      rdata_a <= line_data(int'(mem_addr_a));
      rdata_b <= line_data(int'(mem_addr_b));
    end
  end

  function automatic int clamp(input int s);
    return (s > SYS) ? SYS : s;
  endfunction

  function automatic logic [LW-1:0] model_data(input int a, input int s);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < clamp(s); i++) v[i*DW +: DW] = word(a + i);
    return v;
  endfunction

  function automatic logic hen(input int k);
    if (k < 0) return 1'b0;
    return h_en[k % HN];
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, " wgt_valid"}, LW'(wgt_valid), '0);
    chk({pfx, " wgt_last"}, LW'(wgt_last), '0);
    chk({pfx, " wgt_data"}, wgt_data, '0);
    chk({pfx, " wgt_err"}, LW'(wgt_err), '0);
    chk({pfx, " mem_rd_en"}, LW'(mem_rd_en), '0);
    chk({pfx, " mem_addr_a"}, LW'(mem_addr_a), '0);
    chk({pfx, " mem_addr_b"}, LW'(mem_addr_b), '0);
  endtask

  // Outputs at negedge c reflect edge c-1; request k is sampled at edge k.
  task automatic check_outputs(input int c);
    int r;
    int m;
    int ln;
    logic ev;
    logic el;
    r  = c - 4;
    m  = c - 2;
    ev = hen(r);
    el = ev && !hen(r + 1);
    chk("wgt_valid", LW'(wgt_valid), LW'(ev));
    chk("wgt_last", LW'(wgt_last), LW'(el));
    if (ev) begin
      exp_data = model_data(h_addr[r % HN], h_size[r % HN]);
`ifdef WGT_RESP_BOUND_CHECK_EN
      if (h_addr[r % HN] + clamp(h_size[r % HN]) > RAM) exp_err = 1'b1;
`endif
    end
    chk("wgt_data", wgt_data, exp_data);
    chk("wgt_err", LW'(wgt_err), LW'(exp_err));
    chk("mem_rd_en", LW'(mem_rd_en), LW'(hen(m)));
    if (hen(m)) begin
      ln = h_addr[m % HN] / SYS;
      chk("mem_addr_a", LW'(mem_addr_a), LW'(ln));
      chk("mem_addr_b", LW'(mem_addr_b), LW'((ln + 1 < LINES) ? ln + 1 : 0));
    end
  endtask

  task automatic step(input logic en, input int a, input int s);
    int c;
    @(negedge clk);
    c = cyc;
    check_outputs(c);
    read_en       = en;
    wgt_addr      = AW'(a);
    read_wgt_size = 5'(s);
    h_en[c % HN]   = en;
    h_addr[c % HN] = a;
    h_size[c % HN] = s;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  task automatic rnd_req();
    int a;
    if ($urandom_range(0, 7) == 0) a = RAM - int'($urandom_range(1, 40));
    else a = int'($urandom_range(0, RAM - 1));
    step(1'b1, a, int'($urandom_range(0, 31)));
  endtask

  // Reset lands between edges so its effect is checked as asynchronous.
  task automatic do_reset(input int n);
    int c;
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    read_en = 1'b0;
    #1;
    chk_zero("async_rst");
    c = cyc;
    for (int k = c - 6; k <= c + n + 2; k++) if (k >= 0) h_en[k % HN] = 1'b0;
    exp_data = '0;
    exp_err  = 1'b0;
    cyc++;
    idle(n);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < HN; k++) begin
      h_en[k] = 1'b0;
      h_addr[k] = 0;
      h_size[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    step(1'b1, 32, 16);
    idle(4);
    step(1'b1, 37, 16);
    idle(4);
    step(1'b1, 64, 3);
    step(1'b1, 64, 0);
    idle(4);
    step(1'b1, 101, 25);
    idle(4);

    repeat (9) rnd_req();
    idle(1);
    repeat (5) rnd_req();
    idle(4);
    repeat (9) rnd_req();
    repeat (4) rnd_req();
    idle(4);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) rnd_req();
      else idle(1);
    end
    idle(4);

    step(1'b1, RAM - 16, 16);
    step(1'b1, RAM - 20, 16);
    idle(4);
    step(1'b1, RAM - 4, 16);
    idle(4);
    step(1'b1, 48, 16);
    idle(4);

    rnd_req();
    rnd_req();
    do_reset(3);
    idle(6);
    step(1'b1, 16, 16);
    step(1'b1, 203, 7);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
